// File: rtl/gen_bank_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life double-buffered cell storage.
package gol_pkg;

  localparam int unsigned GOL_DEPTH  = 480000;
  localparam int unsigned GOL_CELL_W = 1;

  typedef enum logic [1:0] {IDLE, LOAD, EVOLVE, FLIP_WAIT} state_t;
  typedef logic [GOL_CELL_W-1:0] cell_t;
  typedef logic bank_t;

endpackage

// File: rtl/gen_bank_ctrl_ld_prio_arbiter.sv
// Fixed-priority loader arbiter: lowest requesting index wins, grant is held
// until its requester drops ld_req (no preemption).
module ld_prio_arbiter #(
  parameter int N_SRC = 3
) (
  input  logic             clk_vga,
  input  logic             reset_btn,
  input  logic             enable,
  input  logic             allow_new,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gnt
);

  logic [N_SRC-1:0] gnt_q;
  logic [N_SRC-1:0] gnt_d;

  always_comb begin
    gnt_d = '0;
    if (enable) begin
      if (|(gnt_q & req)) begin
        gnt_d = gnt_q;
      end else if (allow_new) begin
        // Isolate the lowest set bit of req.
        gnt_d = req & (~req + N_SRC'(1));
      end
    end
  end

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      gnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: rtl/gen_bank_ctrl.sv
// Double-buffered cell storage controller: loader arbitration, evolver bank
// steering and generation flip. Define GEN_VSYNC_FLIP_EN to hold the flip until frame_start.
module gen_bank_ctrl
  import gol_pkg::*;
#(
  parameter int          ADDR_W = 20,
  parameter int unsigned DEPTH  = GOL_DEPTH,
  parameter int          CELL_W = GOL_CELL_W,
  parameter int          N_SRC  = 3
) (
  input  logic                    clk_vga,
  input  logic                    reset_btn,
  input  logic                    load_mode,
  input  logic                    run_en,
  input  logic [N_SRC-1:0]        ld_req,
  input  logic [N_SRC-1:0]        ld_we,
  input  logic [N_SRC*ADDR_W-1:0] ld_addr,
  input  logic [N_SRC*CELL_W-1:0] ld_wdata,
  output logic [N_SRC-1:0]        ld_gnt,
  output logic                    ld_rvalid,
  output logic [CELL_W-1:0]       ld_rdata,
  input  logic [ADDR_W-1:0]       evo_rd_addr,
  output logic [CELL_W-1:0]       evo_rd_data,
  input  logic                    evo_wr_en,
  input  logic [ADDR_W-1:0]       evo_wr_addr,
  input  logic [CELL_W-1:0]       evo_wr_data,
  input  logic                    gen_done,
  output logic                    gen_ready,
  input  logic                    frame_start,
  input  logic [ADDR_W-1:0]       disp_addr,
  output logic [CELL_W-1:0]       disp_data,
  output logic [2*ADDR_W-1:0]     b_addr,
  output logic [1:0]              b_we,
  output logic [2*CELL_W-1:0]     b_wdata,
  input  logic [2*CELL_W-1:0]     b_rdata,
  output logic [ADDR_W-1:0]       d_addr,
  input  logic [2*CELL_W-1:0]     d_rdata,
  output logic                    cur_bank,
  output logic [15:0]             gen_count
);

  state_t      state_q, state_d;
  bank_t       cur_bank_q, cur_bank_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        gen_ready_q, gen_ready_d;
  logic        ld_rvalid_q, ld_rvalid_d;
  bank_t       a_bank_q, a_bank_d;
  logic        a_oor_q, a_oor_d;
  bank_t       d_bank_q, d_bank_d;
  logic        d_oor_q, d_oor_d;

  logic [N_SRC-1:0]  gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [CELL_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [CELL_W-1:0] a_cell;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  ld_prio_arbiter #(.N_SRC(N_SRC)) u_arb (
    .clk_vga   (clk_vga),
    .reset_btn (reset_btn),
    .enable    (state_q == LOAD),
    .allow_new (load_mode),
    .req       (ld_req),
    .gnt       (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        sel_addr  = ld_addr[i*ADDR_W +: ADDR_W];
        sel_we    = ld_we[i];
        sel_wdata = ld_wdata[i*CELL_W +: CELL_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_bank_d  = cur_bank_q;
    gen_count_d = gen_count_q;
    gen_ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_mode) begin
          state_d = LOAD;
        end else if (run_en) begin
          state_d     = EVOLVE;
          gen_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (!load_mode && gnt == '0) state_d = IDLE;
      end
      EVOLVE: begin
        if (gen_done) begin
`ifdef GEN_VSYNC_FLIP_EN
          // A frame_start in this same cycle is deliberately not consumed.
          state_d = FLIP_WAIT;
`else
          state_d     = IDLE;
          cur_bank_d  = ~cur_bank_q;
          gen_count_d = gen_count_q + 16'd1;
`endif
        end
      end
      FLIP_WAIT: begin
`ifdef GEN_VSYNC_FLIP_EN
        if (frame_start) begin
          state_d     = IDLE;
          cur_bank_d  = ~cur_bank_q;
          gen_count_d = gen_count_q + 16'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef GEN_VSYNC_FLIP_EN
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  always_comb begin
    b_addr      = '0;
    b_we        = '0;
    b_wdata     = '0;
    rd_addr     = evo_rd_addr;
    ld_rvalid_d = 1'b0;
    case (state_q)
      LOAD: begin
        // Loader writes go to both banks so either can become current.
        b_addr  = {2{sel_addr}};
        b_wdata = {2{sel_wdata}};
        rd_addr = sel_addr;
        if (|gnt) begin
          if (sel_we) b_we = {2{in_range(sel_addr)}};
          else        ld_rvalid_d = 1'b1;
        end
      end
      EVOLVE, FLIP_WAIT: begin
        if (state_q == EVOLVE) begin
          if (cur_bank_q) begin
            b_addr  = {evo_rd_addr, evo_wr_addr};
            b_wdata = {CELL_W'(0), evo_wr_data};
            b_we    = {1'b0, evo_wr_en && in_range(evo_wr_addr)};
          end else begin
            b_addr  = {evo_wr_addr, evo_rd_addr};
            b_wdata = {evo_wr_data, CELL_W'(0)};
            b_we    = {evo_wr_en && in_range(evo_wr_addr), 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  // Read-data bank selects travel one cycle behind their addresses.
  assign a_bank_d = cur_bank_q;
  assign a_oor_d  = !in_range(rd_addr);
  assign d_bank_d = cur_bank_q;
  assign d_oor_d  = !in_range(disp_addr);

  always_ff @(posedge clk_vga or posedge reset_btn) begin
    if (reset_btn) begin
      state_q     <= IDLE;
      cur_bank_q  <= 1'b0;
      gen_count_q <= '0;
      gen_ready_q <= 1'b0;
      ld_rvalid_q <= 1'b0;
      a_bank_q    <= 1'b0;
      a_oor_q     <= 1'b0;
      d_bank_q    <= 1'b0;
      d_oor_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_bank_q  <= cur_bank_d;
      gen_count_q <= gen_count_d;
      gen_ready_q <= gen_ready_d;
      ld_rvalid_q <= ld_rvalid_d;
      a_bank_q    <= a_bank_d;
      a_oor_q     <= a_oor_d;
      d_bank_q    <= d_bank_d;
      d_oor_q     <= d_oor_d;
    end
  end

  assign a_cell      = a_bank_q ? b_rdata[CELL_W +: CELL_W] : b_rdata[0 +: CELL_W];
  assign ld_rdata    = a_oor_q ? '0 : a_cell;
  assign evo_rd_data = a_oor_q ? '0 : a_cell;
  assign disp_data   = d_oor_q ? '0 :
                       (d_bank_q ? d_rdata[CELL_W +: CELL_W] : d_rdata[0 +: CELL_W]);
  assign d_addr      = disp_addr;
  assign ld_gnt      = gnt;
  assign ld_rvalid   = ld_rvalid_q;
  assign gen_ready   = gen_ready_q;
  assign cur_bank    = cur_bank_q;
  assign gen_count   = gen_count_q;

endmodule
